// File: rtl/boot_loader_if.sv
// Byte-stream input handshake and RAM write port of the boot loader.
// slave is the loader side, master is the stream source / RAM side.
interface boot_loader_if #(
  parameter int ADDRESS_SIZE = 11
);
  logic                    in_valid;
  logic [7:0]              in_data;
  logic                    in_ready;
  logic                    mem_wr_en;
  logic [ADDRESS_SIZE-1:0] mem_wr_addr;
  logic [31:0]             mem_wr_data;

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_wr_en, mem_wr_addr, mem_wr_data
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_wr_en, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/boot_loader.sv
// Loads a length-prefixed big-endian byte image into instruction RAM.
// The core is held in reset until the whole image is written.
module boot_loader #(
  parameter int ADDRESS_SIZE     = 11,
  parameter int INSTRUCTION_SIZE = 20,
  parameter int MAX_WORDS        = 512,
  parameter int COUNT_SIZE       = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  boot_loader_if.slave          bus,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [COUNT_SIZE-1:0] words_loaded
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_BYTE,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                  r_state, w_state_nx;
  logic [7:0]              r_len_hi, w_len_hi_nx;
  logic [COUNT_SIZE-1:0]   r_len, w_len_nx;
  logic [1:0]              r_byte_idx, w_byte_idx_nx;
  logic [31:0]             r_word, w_word_nx;
  logic [COUNT_SIZE-1:0]   r_words_loaded, w_words_loaded_nx;
  logic [ADDRESS_SIZE-1:0] r_wr_addr, w_wr_addr_nx;
  logic [31:0]             r_wr_data, w_wr_data_nx;

  logic                    w_ready;
  logic                    w_xfer;
  logic                    w_wr_en;
  logic [15:0]             w_len_rx;
  logic [31:0]             w_shift;
  logic [COUNT_SIZE-1:0]   w_words_inc;

  // in_ready is a pure function of state so no path exists from in_valid
  assign w_ready     = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) || (r_state == S_BYTE);
  assign w_xfer      = bus.in_valid && w_ready;
  assign w_len_rx    = {r_len_hi, bus.in_data};
  assign w_shift     = {r_word[23:0], bus.in_data};
  assign w_words_inc = r_words_loaded + COUNT_SIZE'(1);

  always_comb begin
    w_state_nx        = r_state;
    w_len_hi_nx       = r_len_hi;
    w_len_nx          = r_len;
    w_byte_idx_nx     = r_byte_idx;
    w_word_nx         = r_word;
    w_words_loaded_nx = r_words_loaded;
    w_wr_addr_nx      = r_wr_addr;
    w_wr_data_nx      = r_wr_data;
    w_wr_en           = 1'b0;

    case (r_state)
      S_LEN_HI: begin
        if (w_xfer) begin
          w_len_hi_nx = bus.in_data;
          w_state_nx  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (w_xfer) begin
          if ((w_len_rx == '0) || (w_len_rx > 16'(MAX_WORDS))) begin
            w_state_nx = S_ERROR;
          end else begin
            w_len_nx      = w_len_rx[COUNT_SIZE-1:0];
            w_byte_idx_nx = 2'd0;
            w_state_nx    = S_BYTE;
          end
        end
      end
      S_BYTE: begin
        if (w_xfer) begin
          w_word_nx     = w_shift;
          w_byte_idx_nx = r_byte_idx + 2'd1;
          if (r_byte_idx == 2'd3) begin
            w_state_nx = S_WRITE;
            // Write port registers only move for a word that will really be written
            if (w_shift[31:INSTRUCTION_SIZE] == '0) begin
              w_wr_data_nx = w_shift;
              w_wr_addr_nx = ADDRESS_SIZE'({r_words_loaded, 2'b00});
            end
          end
        end
      end
      S_WRITE: begin
        if (r_word[31:INSTRUCTION_SIZE] != '0) begin
          w_state_nx = S_ERROR;
        end else begin
          w_wr_en           = 1'b1;
          w_words_loaded_nx = w_words_inc;
          w_byte_idx_nx     = 2'd0;
          w_state_nx        = (w_words_inc == r_len) ? S_DONE : S_BYTE;
        end
      end
      S_DONE:  w_state_nx = S_DONE;
      S_ERROR: w_state_nx = S_ERROR;
      default: w_state_nx = S_LEN_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_LEN_HI;
      r_byte_idx     <= 2'd0;
      r_words_loaded <= '0;
      r_wr_addr      <= '0;
      r_wr_data      <= '0;
    end else begin
      r_state        <= w_state_nx;
      r_byte_idx     <= w_byte_idx_nx;
      r_words_loaded <= w_words_loaded_nx;
      r_wr_addr      <= w_wr_addr_nx;
      r_wr_data      <= w_wr_data_nx;
    end
  end

  // Assembly registers are always reloaded before use, so they carry no reset
  always_ff @(posedge clk) begin
    r_len_hi <= w_len_hi_nx;
    r_len    <= w_len_nx;
    r_word   <= w_word_nx;
  end

  assign bus.in_ready    = w_ready;
  assign bus.mem_wr_en   = w_wr_en;
  assign bus.mem_wr_addr = r_wr_addr;
  assign bus.mem_wr_data = r_wr_data;
  assign done            = (r_state == S_DONE);
  assign error           = (r_state == S_ERROR);
  assign cpu_reset       = (r_state != S_DONE);
  assign words_loaded    = r_words_loaded;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: normal loads, malformed images, reset mid-load.
module tb_boot_loader;

  logic       clk;
  logic       reset;
  logic       cpu_reset;
  logic       done;
  logic       error;
  logic [9:0] words_loaded;

  int n_tests = 0;
  int n_fail  = 0;

  logic [10:0] q_addr[$];
  logic [31:0] q_data[$];

  boot_loader_if #(.ADDRESS_SIZE(11)) bif ();

  boot_loader #(
    .ADDRESS_SIZE(11),
    .INSTRUCTION_SIZE(20),
    .MAX_WORDS(512),
    .COUNT_SIZE(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bif.slave),
    .cpu_reset(cpu_reset),
    .done(done),
    .error(error),
    .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bif.mem_wr_en === 1'b1) begin
      q_addr.push_back(bif.mem_wr_addr);
      q_data.push_back(bif.mem_wr_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bif.in_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int waited;
    waited = 0;
    bif.in_valid = 1'b1;
    bif.in_data  = b;
    while (bif.in_ready !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    assert (waited < 50) else begin
      n_fail++;
      $error("FAIL send_timeout observed=in_ready_low expected=in_ready_high byte=%0h", b);
    end
    tick();
    bif.in_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    send(b);
    tick();
  endtask

  task automatic clear_q();
    q_addr.delete();
    q_data.delete();
  endtask

  logic [7:0] img2 [10];
  int bad;

  initial begin
    img2 = '{8'h00, 8'h02, 8'h00, 8'h0A, 8'hBC, 8'hDE, 8'h00, 8'h01, 8'h23, 8'h45};
    reset = 1'b1;
    bif.in_valid = 1'b0;
    bif.in_data  = 8'h00;
    tick();
    tick();
    reset = 1'b0;

    check("rst_in_ready", 32'(bif.in_ready), 32'd1);
    check("rst_wr_en", 32'(bif.mem_wr_en), 32'd0);
    check("rst_wr_addr", 32'(bif.mem_wr_addr), 32'd0);
    check("rst_wr_data", bif.mem_wr_data, 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);

    // Two-word image, valid held high
    clear_q();
    for (int i = 0; i < 10; i++) begin
      send(img2[i]);
      if (i == 5) check("s1_strobe_latency_w0", 32'(bif.mem_wr_en), 32'd1);
    end
    check("s1_strobe_latency_w1", 32'(bif.mem_wr_en), 32'd1);
    check("s1_done_not_yet", 32'(done), 32'd0);
    tick();
    check("s1_nstrobes", q_addr.size(), 32'd2);
    if (q_addr.size() == 2) begin
      check("s1_addr0", 32'(q_addr[0]), 32'h000);
      check("s1_data0", q_data[0], 32'h000ABCDE);
      check("s1_addr1", 32'(q_addr[1]), 32'h004);
      check("s1_data1", q_data[1], 32'h00012345);
    end
    check("s1_done", 32'(done), 32'd1);
    check("s1_cpu_reset", 32'(cpu_reset), 32'd0);
    check("s1_words", 32'(words_loaded), 32'd2);
    check("s1_error", 32'(error), 32'd0);
    bif.in_valid = 1'b1;
    bif.in_data  = 8'h55;
    tick();
    tick();
    bif.in_valid = 1'b0;
    check("s1_done_ignores_in_ready", 32'(bif.in_ready), 32'd0);
    check("s1_done_ignores_nstrobes", q_addr.size(), 32'd2);
    check("s1_done_hold", 32'(done), 32'd1);

    // Zero length
    do_reset();
    clear_q();
    send(8'h00);
    send(8'h00);
    check("s2_error", 32'(error), 32'd1);
    check("s2_cpu_reset", 32'(cpu_reset), 32'd1);
    check("s2_in_ready", 32'(bif.in_ready), 32'd0);
    check("s2_done", 32'(done), 32'd0);
    tick();
    check("s2_nstrobes", q_addr.size(), 32'd0);

    // Word with bit 20 set
    do_reset();
    clear_q();
    send(8'h00); send(8'h01);
    send(8'h00); send(8'h10); send(8'h00); send(8'h00);
    check("s3_no_strobe_in_write", 32'(bif.mem_wr_en), 32'd0);
    tick();
    check("s3_error", 32'(error), 32'd1);
    check("s3_words", 32'(words_loaded), 32'd0);
    check("s3_nstrobes", q_addr.size(), 32'd0);
    check("s3_wr_data_held", bif.mem_wr_data, 32'd0);

    // Two-word image with valid toggling
    do_reset();
    clear_q();
    for (int i = 0; i < 10; i++) send_gap(img2[i]);
    tick();
    check("s4_nstrobes", q_addr.size(), 32'd2);
    if (q_addr.size() == 2) begin
      check("s4_addr0", 32'(q_addr[0]), 32'h000);
      check("s4_data0", q_data[0], 32'h000ABCDE);
      check("s4_addr1", 32'(q_addr[1]), 32'h004);
      check("s4_data1", q_data[1], 32'h00012345);
    end
    check("s4_done", 32'(done), 32'd1);
    check("s4_words", 32'(words_loaded), 32'd2);
    check("s4_wr_data_held", bif.mem_wr_data, 32'h00012345);

    // Reset after 5 of 10 bytes, then a fresh one-word image
    do_reset();
    clear_q();
    for (int i = 0; i < 5; i++) send(img2[i]);
    do_reset();
    check("s5_in_ready", 32'(bif.in_ready), 32'd1);
    check("s5_words", 32'(words_loaded), 32'd0);
    check("s5_cpu_reset", 32'(cpu_reset), 32'd1);
    check("s5_wr_data", bif.mem_wr_data, 32'd0);
    send(8'h00); send(8'h01);
    send(8'h00); send(8'h00); send(8'h00); send(8'h07);
    tick();
    check("s5_nstrobes", q_addr.size(), 32'd1);
    if (q_addr.size() == 1) begin
      check("s5_addr0", 32'(q_addr[0]), 32'h000);
      check("s5_data0", q_data[0], 32'h00000007);
    end
    check("s5_done", 32'(done), 32'd1);

    // Maximum length image: word i carries value i
    do_reset();
    clear_q();
    send(8'h02); send(8'h00);
    for (int i = 0; i < 512; i++) begin
      send(8'h00);
      send(8'h00);
      send(8'(i >> 8));
      send(8'(i));
    end
    tick();
    check("s6_nstrobes", q_addr.size(), 32'd512);
    bad = 0;
    for (int i = 0; i < q_addr.size(); i++)
      if (q_addr[i] !== 11'(i * 4) || q_data[i] !== 32'(i)) bad++;
    check("s6_seq_errors", 32'(bad), 32'd0);
    if (q_addr.size() == 512) begin
      check("s6_last_addr", 32'(q_addr[511]), 32'h7FC);
      check("s6_last_data", q_data[511], 32'h000001FF);
    end
    check("s6_done", 32'(done), 32'd1);
    check("s6_words", 32'(words_loaded), 32'd512);

    // Length one past the maximum
    do_reset();
    clear_q();
    send(8'h02); send(8'h01);
    check("s6_over_error", 32'(error), 32'd1);
    check("s6_over_done", 32'(done), 32'd0);
    tick();
    check("s6_over_nstrobes", q_addr.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
